unpack_deframer: RTL and testbench
==================================

Name: unpack_deframer

Overview:
- Receive-side counterpart of the packet serializer: consumes the 1-bit packet stream (valid-qualified, no backpressure).
- Finds the 32-bit preamble and strips it.
- Regroups the payload bits into bytes, MSB first, so that byte k of the packet payload is restored exactly.
- Emits bytes with start/end-of-packet flags to the byte-wide sink. Idle (blank) packets pass through as ordinary packets.

Parameters:
- SIZE_BIT_PACK, 1976, total bits per packet including preamble.
- SIZE_PREAMBLE, 32, preamble length in bits.
- PREAMBLE, 32'h1ACFFC1D, preamble pattern; first bit on the wire is PREAMBLE[31].
- SIZE_OUTPUT_BIT, 8, output word width.
- MAX_MISS, 3, consecutive missed preambles before lock is dropped (flywheel only).
- Derived: PAYLOAD_BYTES = (SIZE_BIT_PACK-SIZE_PREAMBLE)/SIZE_OUTPUT_BIT = 243.

Ports:
- i_clk  input  1  clock
- i_reset  input  1  asynchronous, active-high reset
- i_data  input  1  serial bit
- i_valid  input  1  i_data qualifier; a bit is consumed on every cycle i_valid=1
- o_data  output  8  payload byte; first received bit lands in o_data[7]
- o_valid  output  1  one-cycle strobe, o_data valid
- o_sop  output  1  with o_valid: first payload byte of packet
- o_eop  output  1  with o_valid: byte PAYLOAD_BYTES-1
- o_locked  output  1  1 while framing is established
- o_sync_lost  output  1  one-cycle pulse when lock is dropped (flywheel only, else constant 0)

Behaviour:
- Reset state: all outputs 0, state SEARCH, shift register 0, all counters 0, fill counter 0.
- Global rule: cycles with i_valid=0 change no state or counter; o_valid=0 on those cycles.
- Shift register sr[31:0] <= {sr[30:0], i_data} on every i_valid, in every state.
- Fill counter (6 bits) counts bits since entering SEARCH/CHECK and saturates at SIZE_PREAMBLE.
- Match is asserted when the fill counter reaches 31 and {sr[30:0],i_data}==PREAMBLE. This arms the compare only on a full fresh 32-bit window, so payload tail bits never cause a false match.
- SEARCH:
  - on a valid bit with match -> PAYLOAD; bit_cnt=0, byte_cnt=0, o_locked<=1.
  - on a valid bit with fill counter at 31 and no match: stay in SEARCH, sliding bit by bit (fill counter stays saturated).
- PAYLOAD:
  - each valid bit goes into byte_sr (MSB first); bit_cnt counts 3 bits, wrapping 7->0.
  - on bit_cnt==7: next cycle o_valid=1, o_data={byte_sr[6:0],i_data}, o_sop=(byte_cnt==0), o_eop=(byte_cnt==PAYLOAD_BYTES-1); byte_cnt increments.
  - latency: last bit of a byte in -> byte out 1 cycle later.
  - after the byte with o_eop: go to SEARCH (or CHECK with flywheel), fill counter=0, o_locked<=0 (unchanged with flywheel).
  - preamble-shaped patterns inside the payload are ignored.
- Back-to-back packets: the next preamble's 32nd bit produces a match with zero gap; no bit is lost.
- Reset asserted mid-packet: immediate return to reset state; the partial packet is discarded and no o_eop is issued.
- o_sop/o_eop are 0 whenever o_valid=0.

Optional Feature:
- Macro UNPACK_FLYWHEEL_EN.
- Defined:
  - after o_eop, state goes to CHECK (collects 32 bits, o_locked stays 1).
  - on the 32nd bit: match -> PAYLOAD, miss_cnt=0.
  - no match and miss_cnt+1 < MAX_MISS -> miss_cnt++, PAYLOAD anyway (framing held by count).
  - no match and miss_cnt+1 == MAX_MISS -> SEARCH, o_locked<=0, miss_cnt=0, o_sync_lost pulses 1 cycle.
- Not defined: no CHECK state, no miss_cnt; after o_eop go straight to SEARCH; o_sync_lost tied 0.

Test Plan:
- Reset, then 100 random bits, PREAMBLE, then 1944 payload bits of bytes 0x00..0xF2 MSB first -> 243 o_valid strobes, bytes 0x00..0xF2 in order, o_sop on 0x00, o_eop on 0xF2, o_locked 1 from the cycle after the last preamble bit.
- Two packets back-to-back, payload bytes 0xA5 repeated in both -> 486 bytes, exactly two sop/eop pairs, no gap at the boundary.
- i_valid toggling 1/0 each cycle during a packet -> same byte sequence, o_valid never asserted on a cycle following an i_valid=0 cycle.
- Payload containing 0x1ACFFC1D at byte 10 -> no resync; byte_cnt continues and o_eop still falls at byte 242.
- Reset pulsed after byte 100 -> outputs 0 immediately, no o_eop; the next full packet decodes correctly.
- Flywheel build: good packet, then 3 packets with corrupted preamble (0x00000000) -> packets 2 and 3 still emit 243 bytes each; the 4th preamble miss gives o_sync_lost pulse and o_locked=0. Non-flywheel build, same stimulus -> only packet 1 decoded.

Source files
------------

// File: rtl/unpack_deframer.sv
// rtl/unpack_deframer.sv - serial packet deframer: preamble hunt, payload regrouped into MSB-first bytes
//
// Optional feature: define UNPACK_FLYWHEEL_EN to hold framing across up to
// MAX_MISS-1 consecutive corrupted preambles (adds CHECK state and miss counter).
//
// Ports:
//   i_clk        clock
//   i_reset      asynchronous, active-high reset
//   i_data       serial bit, consumed when i_valid=1
//   i_valid      qualifier for i_data
//   o_data       payload byte, first received bit in o_data[7]
//   o_valid      one-cycle strobe qualifying o_data/o_sop/o_eop
//   o_sop        first payload byte of a packet
//   o_eop        last payload byte of a packet
//   o_locked     framing established
//   o_sync_lost  one-cycle pulse when lock is dropped (flywheel build only)
module unpack_deframer #(
  parameter int          SIZE_BIT_PACK   = 1976,
  parameter int          SIZE_PREAMBLE   = 32,
  parameter logic [31:0] PREAMBLE        = 32'h1ACFFC1D,
  parameter int          SIZE_OUTPUT_BIT = 8,
  parameter int          MAX_MISS        = 3
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_data,
  input  logic                       i_valid,
  output logic [SIZE_OUTPUT_BIT-1:0] o_data,
  output logic                       o_valid,
  output logic                       o_sop,
  output logic                       o_eop,
  output logic                       o_locked,
  output logic                       o_sync_lost
);

  localparam int PAYLOAD_BYTES = (SIZE_BIT_PACK - SIZE_PREAMBLE) / SIZE_OUTPUT_BIT;
  localparam int BCW           = $clog2(PAYLOAD_BYTES);
  localparam int BTW           = $clog2(SIZE_OUTPUT_BIT);

  localparam logic [BCW-1:0] LAST_BYTE = BCW'(PAYLOAD_BYTES - 1);
  localparam logic [BTW-1:0] LAST_BIT  = BTW'(SIZE_OUTPUT_BIT - 1);
  localparam logic [5:0]     FILL_MAX  = 6'(SIZE_PREAMBLE);
  localparam logic [5:0]     FILL_ARM  = 6'(SIZE_PREAMBLE - 1);

`ifdef UNPACK_FLYWHEEL_EN
  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_PAYLOAD = 2'd1,
    S_CHECK   = 2'd2
  } state_t;
  localparam int MW = $clog2(MAX_MISS + 1);
`else
  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_PAYLOAD = 2'd1
  } state_t;
`endif

  state_t                     state_q, state_d;
  // Only the 31 most recent bits are kept: the oldest bit of the 32-bit
  // window is always shifted out before it could take part in a compare.
  logic [SIZE_PREAMBLE-2:0]   sr_q, sr_d;
  logic [5:0]                 fill_q, fill_d;
  logic [BTW-1:0]             bit_cnt_q, bit_cnt_d;
  logic [SIZE_OUTPUT_BIT-2:0] byte_sr_q, byte_sr_d;
  logic [BCW-1:0]             byte_cnt_q, byte_cnt_d;
  logic [SIZE_OUTPUT_BIT-1:0] data_q, data_d;
  logic                       valid_q, valid_d;
  logic                       sop_q, sop_d;
  logic                       eop_q, eop_d;
  logic                       locked_q, locked_d;
`ifdef UNPACK_FLYWHEEL_EN
  logic [MW-1:0]              miss_q, miss_d;
  logic                       lost_q, lost_d;
`endif

  logic [SIZE_PREAMBLE-1:0]   window;
  logic                       armed;
  logic                       match;
  logic [5:0]                 fill_inc;

  assign window   = {sr_q, i_data};
  // Compare only once a full window of bits gathered since (re)entering the
  // hunt is present, so payload tail bits never alias into a preamble.
  assign armed    = (fill_q >= FILL_ARM);
  assign match    = armed && (window == PREAMBLE);
  assign fill_inc = (fill_q == FILL_MAX) ? fill_q : fill_q + 6'd1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_SEARCH;
      sr_q       <= '0;
      fill_q     <= '0;
      bit_cnt_q  <= '0;
      byte_sr_q  <= '0;
      byte_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      locked_q   <= 1'b0;
`ifdef UNPACK_FLYWHEEL_EN
      miss_q     <= '0;
      lost_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      fill_q     <= fill_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_sr_q  <= byte_sr_d;
      byte_cnt_q <= byte_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      locked_q   <= locked_d;
`ifdef UNPACK_FLYWHEEL_EN
      miss_q     <= miss_d;
      lost_q     <= lost_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    fill_d     = fill_q;
    bit_cnt_d  = bit_cnt_q;
    byte_sr_d  = byte_sr_q;
    byte_cnt_d = byte_cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    sop_d      = 1'b0;
    eop_d      = 1'b0;
    locked_d   = locked_q;
`ifdef UNPACK_FLYWHEEL_EN
    miss_d     = miss_q;
    lost_d     = 1'b0;
`endif

    if (i_valid) begin
      sr_d = window[SIZE_PREAMBLE-2:0];
      case (state_q)
        S_SEARCH: begin
          if (match) begin
            state_d    = S_PAYLOAD;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            locked_d   = 1'b1;
          end else begin
            fill_d = fill_inc;
          end
        end

        S_PAYLOAD: begin
          byte_sr_d = {byte_sr_q[SIZE_OUTPUT_BIT-3:0], i_data};
          bit_cnt_d = bit_cnt_q + BTW'(1);
          if (bit_cnt_q == LAST_BIT) begin
            valid_d = 1'b1;
            data_d  = {byte_sr_q, i_data};
            sop_d   = (byte_cnt_q == '0);
            eop_d   = (byte_cnt_q == LAST_BYTE);
            if (byte_cnt_q == LAST_BYTE) begin
              byte_cnt_d = '0;
              fill_d     = '0;
`ifdef UNPACK_FLYWHEEL_EN
              state_d    = S_CHECK;
`else
              state_d    = S_SEARCH;
              locked_d   = 1'b0;
`endif
            end else begin
              byte_cnt_d = byte_cnt_q + BCW'(1);
            end
          end
        end

`ifdef UNPACK_FLYWHEEL_EN
        S_CHECK: begin
          if (armed) begin
            fill_d = '0;
            if (match) begin
              state_d    = S_PAYLOAD;
              miss_d     = '0;
              bit_cnt_d  = '0;
              byte_cnt_d = '0;
            end else if (int'(miss_q) + 1 < MAX_MISS) begin
              // Framing is held by count alone for this packet.
              state_d    = S_PAYLOAD;
              miss_d     = miss_q + MW'(1);
              bit_cnt_d  = '0;
              byte_cnt_d = '0;
            end else begin
              state_d  = S_SEARCH;
              miss_d   = '0;
              locked_d = 1'b0;
              lost_d   = 1'b1;
            end
          end else begin
            fill_d = fill_inc;
          end
        end
`endif

        default: begin
          state_d = S_SEARCH;
          fill_d  = '0;
        end
      endcase
    end
  end

  assign o_data   = data_q;
  assign o_valid  = valid_q;
  assign o_sop    = sop_q;
  assign o_eop    = eop_q;
  assign o_locked = locked_q;
`ifdef UNPACK_FLYWHEEL_EN
  assign o_sync_lost = lost_q;
`else
  assign o_sync_lost = 1'b0;
`endif

endmodule

// File: tb/tb_unpack_deframer.sv
// tb/tb_unpack_deframer.sv - self-checking bench for unpack_deframer
module tb_unpack_deframer;

  localparam logic [31:0] PRE      = 32'h1ACFFC1D;
  localparam int          PB       = 243;
  localparam int          MAX_MISS = 3;
`ifdef UNPACK_FLYWHEEL_EN
  localparam bit FW = 1'b1;
`else
  localparam bit FW = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d   = 1'b0;
  logic       v   = 1'b0;
  logic [7:0] od;
  logic       ov, osop, oeop, olock, olost;

  always #5 clk = ~clk;

  unpack_deframer dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_data      (d),
    .i_valid     (v),
    .o_data      (od),
    .o_valid     (ov),
    .o_sop       (osop),
    .o_eop       (oeop),
    .o_locked    (olock),
    .o_sync_lost (olost)
  );

  typedef struct {
    logic [7:0] b;
    bit         sop;
    bit         eop;
  } ev_t;

  typedef struct {
    int n_rand;
    int pat;
    int pkts;
    bit toggle;
    bit corrupt;
    int exp_bytes;
    int exp_pkts;
    int exp_lost;
    bit exp_lock_end;
  } vec_t;

  int  vectors    = 0;
  int  miscompares = 0;
  int  n_bytes = 0, n_sop = 0, n_eop = 0, n_lost = 0;
  ev_t exp_q[$];
  bit  stream_q[$];

  function automatic void chk(string name, int got, int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  function automatic void push_word(logic [31:0] w);
    for (int i = 31; i >= 0; i--) stream_q.push_back(w[i]);
  endfunction

  function automatic void push_byte(logic [7:0] b);
    for (int i = 7; i >= 0; i--) stream_q.push_back(b[i]);
  endfunction

  // pat 0: byte k = k; pat 1: 0xA5; pat 2: byte k = k with PRE embedded at bytes 10..13
  function automatic void push_packet(int pat, bit bad_pre);
    logic [31:0] p;
    p = PRE;
    push_word(bad_pre ? 32'h0 : p);
    for (int k = 0; k < PB; k++) begin
      if (pat == 1) push_byte(8'hA5);
      else if (pat == 2 && k >= 10 && k <= 13) push_byte(p[31-8*(k-10) -: 8]);
      else push_byte(8'(k));
    end
  endfunction

  function automatic logic [31:0] win(int end_idx);
    logic [31:0] w = '0;
    for (int i = 0; i < 32; i++) w = {w[30:0], stream_q[end_idx-31+i]};
    return w;
  endfunction

  // Stream-level reference: hunt for the preamble in fresh bits, take 243
  // bytes, then hunt again (or check the next 32 bits with the flywheel).
  function automatic int run_model();
    int p = 0, miss = 0, j, lost = 0;
    bit chk_mode = 1'b0, done = 1'b0, acq;
    logic [7:0] by;
    while (!done) begin
      acq = 1'b0;
      if (!chk_mode) begin
        j = p + 31;
        while (!acq && j < stream_q.size()) begin
          if (win(j) == PRE) acq = 1'b1;
          else j++;
        end
        if (acq) p = j + 1;
        else done = 1'b1;
      end else if (p + 32 > stream_q.size()) begin
        done = 1'b1;
      end else begin
        if (win(p + 31) == PRE) begin miss = 0; acq = 1'b1; end
        else if (miss + 1 < MAX_MISS) begin miss++; acq = 1'b1; end
        else begin lost++; miss = 0; chk_mode = 1'b0; end
        p += 32;
      end
      if (acq) begin
        for (int k = 0; k < PB && !done; k++) begin
          if (p + 8 > stream_q.size()) done = 1'b1;
          else begin
            for (int i = 0; i < 8; i++) by[7-i] = stream_q[p+i];
            exp_q.push_back('{by, k == 0, k == PB-1});
            p += 8;
          end
        end
        chk_mode = FW;
      end
    end
    return lost;
  endfunction

  task automatic drive(input bit dd, input bit vv);
    d = dd;
    v = vv;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    d = 1'b0;
    v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic apply(input bit toggle, input int lock_idx);
    for (int i = 0; i < stream_q.size(); i++) begin
      drive(stream_q[i], 1'b1);
      if (i == lock_idx - 1) chk("locked_before_last_pre_bit", int'(olock), 0);
      if (i == lock_idx)     chk("locked_after_last_pre_bit", int'(olock), 1);
      if (toggle) drive(1'($urandom_range(0, 1)), 1'b0);
    end
    repeat (4) drive(1'b0, 1'b0);
  endtask

  task automatic monitor();
    logic prev_v = 1'b0;
    ev_t  e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (olost) n_lost++;
        if (ov) begin
          chk("valid_after_idle_cycle", int'(prev_v), 1);
          n_bytes++;
          n_sop += int'(osop);
          n_eop += int'(oeop);
          if (exp_q.size() == 0) chk("unexpected_byte", int'(od), -1);
          else begin
            e = exp_q.pop_front();
            chk("byte", int'(od), int'(e.b));
            chk("sop", int'(osop), int'(e.sop));
            chk("eop", int'(oeop), int'(e.eop));
          end
        end else if (osop || oeop) begin
          chk("flag_without_valid", int'(osop | oeop), 0);
        end
      end
      prev_v = v;
    end
  endtask

  vec_t tbl[5];

  initial begin
    int b0, s0, e0, l0, lost_exp;

    tbl[0] = '{100, 0, 1, 1'b0, 1'b0, 243, 1, 0, FW};
    tbl[1] = '{37,  1, 2, 1'b0, 1'b0, 486, 2, 0, FW};
    tbl[2] = '{20,  0, 1, 1'b1, 1'b0, 243, 1, 0, FW};
    tbl[3] = '{5,   2, 1, 1'b0, 1'b0, 243, 1, 0, FW};
    tbl[4] = '{0,   1, 4, 1'b0, 1'b1, FW ? 729 : 243, FW ? 3 : 1, FW ? 1 : 0, 1'b0};

    fork
      monitor();
    join_none

    do_reset();
    chk("reset_o_data", int'(od), 0);
    chk("reset_o_valid", int'(ov), 0);
    chk("reset_o_sop", int'(osop), 0);
    chk("reset_o_eop", int'(oeop), 0);
    chk("reset_o_locked", int'(olock), 0);
    chk("reset_o_sync_lost", int'(olost), 0);

    for (int t = 0; t < 5; t++) begin
      do_reset();
      stream_q.delete();
      for (int i = 0; i < tbl[t].n_rand; i++) stream_q.push_back(1'($urandom_range(0, 1)));
      for (int k = 0; k < tbl[t].pkts; k++) push_packet(tbl[t].pat, tbl[t].corrupt && k > 0);
      lost_exp = run_model();
      chk("model_lost_vs_table", lost_exp, tbl[t].exp_lost);
      b0 = n_bytes; s0 = n_sop; e0 = n_eop; l0 = n_lost;
      apply(tbl[t].toggle, tbl[t].n_rand + 31);
      chk("byte_count", n_bytes - b0, tbl[t].exp_bytes);
      chk("sop_count", n_sop - s0, tbl[t].exp_pkts);
      chk("eop_count", n_eop - e0, tbl[t].exp_pkts);
      chk("sync_lost_count", n_lost - l0, tbl[t].exp_lost);
      chk("locked_at_end", int'(olock), int'(tbl[t].exp_lock_end));
      chk("pending_expected_bytes", exp_q.size(), 0);
    end

    // Reset in the middle of a packet: bytes 0..100 out, no eop, all outputs cleared.
    do_reset();
    stream_q.delete();
    push_packet(0, 1'b0);
    while (stream_q.size() > 32 + 101 * 8) void'(stream_q.pop_back());
    void'(run_model());
    b0 = n_bytes; e0 = n_eop;
    apply(1'b0, 31);
    chk("partial_byte_count", n_bytes - b0, 101);
    chk("partial_eop_count", n_eop - e0, 0);
    chk("partial_locked", int'(olock), 1);
    rst = 1'b1;
    #1;
    chk("midreset_o_data", int'(od), 0);
    chk("midreset_o_locked", int'(olock), 0);
    chk("midreset_o_valid", int'(ov), 0);
    chk("midreset_flags", int'({osop, oeop, olost}), 0);
    do_reset();
    stream_q.delete();
    push_packet(0, 1'b0);
    void'(run_model());
    b0 = n_bytes; s0 = n_sop; e0 = n_eop;
    apply(1'b0, 31);
    chk("post_reset_byte_count", n_bytes - b0, 243);
    chk("post_reset_sop_count", n_sop - s0, 1);
    chk("post_reset_eop_count", n_eop - e0, 1);
    chk("post_reset_pending", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
